// File: rtl/diagv2_dmem_if.sv
// Data-memory bus between the RV64 memory stage and diagv2_dmem.
// The console drain signals exist only when DIAGV2_DMEM_MMIO_EN is defined.
interface diagv2_dmem_if;
    logic [63:0] addr;
    logic [63:0] writeData;
    logic        memWrite;
    logic [2:0]  memType;
    logic [63:0] readData;
    logic        errSticky;
`ifdef DIAGV2_DMEM_MMIO_EN
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
`endif

    modport master (
        output addr, writeData, memWrite, memType,
        input  readData, errSticky
`ifdef DIAGV2_DMEM_MMIO_EN
        , input txData, txValid
        , output txReady
`endif
    );

    modport slave (
        input  addr, writeData, memWrite, memType,
        output readData, errSticky
`ifdef DIAGV2_DMEM_MMIO_EN
        , output txData, txValid
        , input txReady
`endif
    );
endinterface

// File: rtl/diagv2_dmem.sv
// Byte-addressed data memory with sub-word load extension and store merging.
// Define DIAGV2_DMEM_MMIO_EN to add the cycle counter, console TX FIFO and STATUS register.
module diagv2_dmem #(
    parameter int    DEPTH_WORDS = 1024,
    parameter string INIT_FILE   = ""
) (
    input  logic         clk,
    input  logic         reset,
    diagv2_dmem_if.slave bus
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [63:0] RAM_BYTES = 64'(DEPTH_WORDS) << 3;

    logic [63:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] wordIdx;
    logic [1:0]       sizeCode;
    logic             illegalType;
    logic             misaligned;
    logic             inRam;
    logic             decoded;
    logic             accErr;
    logic [5:0]       shiftAmt;
    logic [63:0]      rawWord;
    logic [63:0]      shifted;
    logic [63:0]      loadVal;
    logic [63:0]      laneData;
    logic [7:0]       sizeMask;
    logic [7:0]       laneMask;
    logic             ramWe;
    logic             errStickyQ;

    assign wordIdx     = bus.addr[IDX_W+2:3];
    assign sizeCode    = bus.memType[1:0];
    assign illegalType = (bus.memType == 3'b111);
    assign inRam       = (bus.addr < RAM_BYTES);
    assign shiftAmt    = {bus.addr[2:0], 3'b000};

    always_comb begin
        misaligned = 1'b0;
        sizeMask   = 8'h01;
        case (sizeCode)
            2'b00: begin misaligned = 1'b0;            sizeMask = 8'h01; end
            2'b01: begin misaligned = bus.addr[0];     sizeMask = 8'h03; end
            2'b10: begin misaligned = |bus.addr[1:0];  sizeMask = 8'h0F; end
            2'b11: begin misaligned = |bus.addr[2:0];  sizeMask = 8'hFF; end
        endcase
    end

`ifdef DIAGV2_DMEM_MMIO_EN
    localparam logic [63:0] TX_ADDR     = 64'h0000_0000_1000_0000;
    localparam logic [63:0] CYCLE_ADDR  = 64'h0000_0000_1000_0008;
    localparam logic [63:0] STATUS_ADDR = 64'h0000_0000_1000_0010;

    logic        isTx;
    logic        isCycle;
    logic        isStatus;
    logic [63:0] cycleCount;
    logic [7:0]  fifo [4];
    logic [1:0]  wrPtr;
    logic [1:0]  rdPtr;
    logic [2:0]  count;
    logic        overflow;
    logic        full;
    logic        push;
    logic        pop;

    assign isTx     = (bus.addr == TX_ADDR);
    assign isCycle  = (bus.addr == CYCLE_ADDR);
    assign isStatus = (bus.addr == STATUS_ADDR);
    assign decoded  = inRam | isTx | isCycle | isStatus;
`else
    assign decoded  = inRam;
`endif

    assign accErr = illegalType | misaligned | ~decoded;

    // MMIO registers sit at 8-byte aligned addresses, so the lane shift is zero for them.
    always_comb begin
        rawWord = '0;
        if (inRam) begin
            rawWord = mem[wordIdx];
        end
`ifdef DIAGV2_DMEM_MMIO_EN
        else if (isCycle) begin
            rawWord = cycleCount;
        end
        else if (isStatus) begin
            rawWord = {59'b0, overflow, count, full};
        end
`endif
    end

    assign shifted = rawWord >> shiftAmt;

    always_comb begin
        loadVal = shifted;
        case (sizeCode)
            2'b00: loadVal = {{56{shifted[7]  & ~bus.memType[2]}}, shifted[7:0]};
            2'b01: loadVal = {{48{shifted[15] & ~bus.memType[2]}}, shifted[15:0]};
            2'b10: loadVal = {{32{shifted[31] & ~bus.memType[2]}}, shifted[31:0]};
            2'b11: loadVal = shifted;
        endcase
    end

    assign bus.readData = accErr ? 64'd0 : loadVal;

    assign laneMask = sizeMask << bus.addr[2:0];
    assign laneData = bus.writeData << shiftAmt;
    assign ramWe    = bus.memWrite & ~accErr & inRam;

    // RAM keeps its contents across reset; only the addressed byte lanes are written.
    always_ff @(posedge clk) begin
        if (ramWe) begin
            for (int i = 0; i < 8; i++) begin
                if (laneMask[i]) begin
                    mem[wordIdx][i*8 +: 8] <= laneData[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            errStickyQ <= 1'b0;
        end else if (accErr) begin
            errStickyQ <= 1'b1;
        end
    end

    assign bus.errSticky = errStickyQ;

`ifdef DIAGV2_DMEM_MMIO_EN
    assign full        = (count == 3'd4);
    assign push        = bus.memWrite & isTx & ~accErr;
    assign pop         = bus.txValid & bus.txReady;
    assign bus.txValid = (count != 3'd0);
    assign bus.txData  = fifo[rdPtr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycleCount <= 64'd0;
        end else begin
            cycleCount <= cycleCount + 64'd1;
        end
    end

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                fifo[i] <= 8'd0;
            end
            wrPtr    <= 2'd0;
            rdPtr    <= 2'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            if (push && (pop || !full)) begin
                fifo[wrPtr] <= bus.writeData[7:0];
                wrPtr       <= wrPtr + 2'd1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 2'd1;
            end
            if (push && !pop && full) begin
                overflow <= 1'b1;
            end
            if (push && !pop && !full) begin
                count <= count + 3'd1;
            end else if (pop && !push) begin
                count <= count - 3'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_diagv2_dmem.sv
// Scoreboard bench for diagv2_dmem: a byte-array reference model predicts each response,
// a negedge monitor compares readData, errSticky and the console byte stream.
module tb_diagv2_dmem;

    localparam int          DEPTH     = 64;
    localparam logic [63:0] RAM_BYTES = 64'(DEPTH) * 64'd8;
    localparam logic [63:0] TX_A      = 64'h1000_0000;
    localparam logic [63:0] CYC_A     = 64'h1000_0008;
    localparam logic [63:0] STAT_A    = 64'h1000_0010;

    typedef struct {
        string       name;
        bit          chkRd;
        logic [63:0] rd;
        bit          err;
    } expT;

    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   tbChk = 1'b0;
    int   checks = 0;
    int   errors = 0;

    expT         sb[$];
    logic [7:0]  txExp[$];
    logic [7:0]  refMem [DEPTH*8];
    logic [63:0] modelCycle = 64'd0;
    bit          modelErr = 1'b0;
    int          modelCount = 0;
    bit          modelOvf = 1'b0;

    diagv2_dmem_if bus ();

    diagv2_dmem #(.DEPTH_WORDS(DEPTH), .INIT_FILE("")) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
        end
    endtask

    function automatic bit modelErrOf(input logic [63:0] a, input logic [2:0] t);
        logic [63:0] size;
        bit          dec;
        size = 64'd1 << t[1:0];
        dec  = (a < RAM_BYTES);
`ifdef DIAGV2_DMEM_MMIO_EN
        dec  = dec || (a == TX_A) || (a == CYC_A) || (a == STAT_A);
`endif
        return (t == 3'b111) || ((a % size) != 64'd0) || !dec;
    endfunction

    function automatic logic [63:0] modelRead(input logic [63:0] a, input logic [2:0] t);
        logic [63:0] size;
        logic [63:0] v;
        logic [63:0] mask;
        v    = 64'd0;
        size = 64'd1 << t[1:0];
        if (modelErrOf(a, t)) return 64'd0;
        if (a < RAM_BYTES) begin
            for (int i = 0; i < int'(size); i++) v = v | (64'(refMem[int'(a) + i]) << (8 * i));
        end
`ifdef DIAGV2_DMEM_MMIO_EN
        else if (a == CYC_A) v = modelCycle;
        else if (a == STAT_A) v = 64'(modelOvf) * 16 + 64'(modelCount) * 2 + 64'(modelCount == 4);
`endif
        if (size < 64'd8) begin
            mask = (64'd1 << (8 * size)) - 64'd1;
            v    = v & mask;
            if (!t[2] && v[8*size-1]) v = v | ~mask;
        end
        return v;
    endfunction

    // Drives one cycle, queues the predicted response, then advances the model past the edge.
    task automatic applyStimulus(input bit wr, input logic [2:0] t, input logic [63:0] a,
                                 input logic [63:0] d, input bit chk, input string name,
                                 input bit useExp = 1'b0, input logic [63:0] expRd = 64'd0);
        expT e;
        bit  err;
        bit  popNow;
        bit  pushNow;
        bus.memWrite  = wr;
        bus.memType   = t;
        bus.addr      = a;
        bus.writeData = d;
        err = modelErrOf(a, t);
        if (chk) begin
            e.name  = name;
            e.chkRd = !wr;
            e.rd    = useExp ? expRd : modelRead(a, t);
            e.err   = modelErr;
            sb.push_back(e);
            tbChk = 1'b1;
        end
        popNow  = 1'b0;
        pushNow = 1'b0;
`ifdef DIAGV2_DMEM_MMIO_EN
        popNow  = bus.txReady && (modelCount > 0);
        pushNow = wr && !err && (a == TX_A);
`endif
        @(posedge clk);
        #1;
        tbChk = 1'b0;
        modelCycle = modelCycle + 64'd1;
        if (err) modelErr = 1'b1;
        if (wr && !err && a < RAM_BYTES) begin
            for (int i = 0; i < (1 << t[1:0]); i++) refMem[int'(a) + i] = 8'(d >> (8 * i));
        end
        if (pushNow && !popNow && modelCount == 4) begin
            modelOvf = 1'b1;
        end else if (pushNow) begin
            txExp.push_back(d[7:0]);
            if (!popNow) modelCount++;
        end else if (popNow) begin
            modelCount--;
        end
    endtask

    task automatic idle(input bit chk = 1'b0, input string name = "idle");
        applyStimulus(1'b0, 3'b011, 64'd0, 64'd0, chk, name);
    endtask

    task automatic clearModel();
        modelCycle = 64'd0;
        modelErr   = 1'b0;
        modelCount = 0;
        modelOvf   = 1'b0;
        txExp.delete();
    endtask

    task automatic doReset();
        tbChk         = 1'b0;
        reset         = 1'b1;
        bus.memWrite  = 1'b0;
        bus.memType   = 3'b011;
        bus.addr      = 64'd0;
        bus.writeData = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        clearModel();
    endtask

    task automatic errCase(input bit wr, input logic [2:0] t, input logic [63:0] a,
                           input string name, input int holdCycles);
        doReset();
        applyStimulus(wr, t, a, 64'h5A5A, 1'b1, name);
        for (int i = 0; i <= holdCycles; i++) idle(1'b1, {name, " sticky"});
    endtask

    always @(negedge clk) begin
        expT e;
        if (tbChk) begin
            if (sb.size() == 0) begin
                checkOutput("scoreboard underflow", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                if (e.chkRd) checkOutput(e.name, bus.readData, e.rd);
                checkOutput({e.name, " errSticky"}, 64'(bus.errSticky), 64'(e.err));
            end
        end
`ifdef DIAGV2_DMEM_MMIO_EN
        if (!reset && bus.txValid && bus.txReady) begin
            if (txExp.size() == 0) checkOutput("unexpected tx byte", 64'(bus.txData), 64'hXX);
            else checkOutput("tx byte", 64'(bus.txData), 64'(txExp.pop_front()));
        end
`endif
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] a;
        logic [63:0] d;
        logic [2:0]  t;
        int          r;
        bit          wr;
`ifdef DIAGV2_DMEM_MMIO_EN
        bus.txReady = 1'b0;
`endif
        doReset();
        $display("[TB] initialising RAM");
        for (int w = 0; w < DEPTH; w++) applyStimulus(1'b1, 3'b011, 64'(w * 8), {$urandom, $urandom}, 1'b0, "init");
        idle(1'b1, "after init");

        applyStimulus(1'b1, 3'b011, 64'h10, 64'h8877665544332211, 1'b1, "sd 0x10");
        applyStimulus(1'b1, 3'b000, 64'h11, 64'h00000000000000AA, 1'b1, "sb 0x11");
        applyStimulus(1'b0, 3'b011, 64'h10, 64'd0, 1'b1, "ld 0x10",  1'b1, 64'h887766554433AA11);
        applyStimulus(1'b0, 3'b000, 64'h11, 64'd0, 1'b1, "lb 0x11",  1'b1, 64'hFFFFFFFFFFFFFFAA);
        applyStimulus(1'b0, 3'b100, 64'h11, 64'd0, 1'b1, "lbu 0x11", 1'b1, 64'h00000000000000AA);
        applyStimulus(1'b0, 3'b010, 64'h14, 64'd0, 1'b1, "lw 0x14",  1'b1, 64'hFFFFFFFF88776655);
        applyStimulus(1'b0, 3'b110, 64'h14, 64'd0, 1'b1, "lwu 0x14", 1'b1, 64'h0000000088776655);
        applyStimulus(1'b0, 3'b001, 64'h12, 64'd0, 1'b1, "lh 0x12");

        doReset();
        for (int i = 0; i < 10; i++) idle();
`ifdef DIAGV2_DMEM_MMIO_EN
        applyStimulus(1'b0, 3'b011, CYC_A, 64'd0, 1'b1, "ld CYCLE", 1'b1, 64'd10);
        applyStimulus(1'b1, 3'b011, CYC_A, 64'hFFFF, 1'b1, "sd CYCLE ignored");
        applyStimulus(1'b0, 3'b011, CYC_A, 64'd0, 1'b1, "ld CYCLE again");

        $display("[TB] FIFO fill with overflow");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 3'b000, TX_A, 64'(8'h41 + i), 1'b0, "sb TX");
        applyStimulus(1'b0, 3'b011, TX_A, 64'd0, 1'b1, "ld TX");
        applyStimulus(1'b0, 3'b011, STAT_A, 64'd0, 1'b1, "STATUS full+ovf", 1'b1, 64'h19);
        bus.txReady = 1'b1;
        for (int i = 0; i < 6; i++) idle();
        bus.txReady = 1'b0;
        checkOutput("txValid after drain", 64'(bus.txValid), 64'd0);
        checkOutput("drain left bytes", 64'(txExp.size()), 64'd0);

        $display("[TB] FIFO simultaneous push and pop");
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 3'b010, TX_A, 64'(8'hC0 + i), 1'b0, "sw TX");
        applyStimulus(1'b0, 3'b011, STAT_A, 64'd0, 1'b1, "STATUS full");
        bus.txReady = 1'b1;
        applyStimulus(1'b1, 3'b011, TX_A, 64'hD5, 1'b1, "sd TX push+pop");
        bus.txReady = 1'b0;
        applyStimulus(1'b0, 3'b011, STAT_A, 64'd0, 1'b1, "STATUS after push+pop", 1'b1, 64'h09);
        bus.txReady = 1'b1;
        idle();
        idle();
        checkOutput("txValid mid-drain", 64'(bus.txValid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("txValid async reset", 64'(bus.txValid), 64'd0);
        checkOutput("txData reset", 64'(bus.txData), 64'd0);
        bus.txReady = 1'b0;
        doReset();
        errCase(1'b0, 3'b011, 64'h1000_0018, "ld undecoded MMIO", 0);
`else
        applyStimulus(1'b0, 3'b011, CYC_A, 64'd0, 1'b1, "ld absent CYCLE");
        idle(1'b1, "absent CYCLE sticky");
`endif

        $display("[TB] error cases");
        errCase(1'b0, 3'b001, 64'h3, "lh misaligned 0x3", 3);
        errCase(1'b0, 3'b011, RAM_BYTES, "ld past RAM", 0);
        errCase(1'b0, 3'b111, 64'h0, "illegal memType", 0);
        errCase(1'b1, 3'b010, 64'h102, "sw misaligned", 0);
        applyStimulus(1'b0, 3'b011, 64'h100, 64'd0, 1'b1, "ld after dropped sw");

        $display("[TB] randomized traffic");
        doReset();
        for (int n = 0; n < 400; n++) begin
            r  = int'($urandom_range(0, 15));
            t  = 3'($urandom_range(0, 6));
            if (r == 0) t = 3'b111;
            a  = 64'($urandom_range(0, 511));
            if (r == 1) a = RAM_BYTES + 64'($urandom_range(0, 4095));
            else if (r > 3) a = a & ~((64'd1 << t[1:0]) - 64'd1);
            wr = 1'($urandom_range(0, 1));
            d  = {$urandom, $urandom};
            applyStimulus(wr, t, a, d, 1'b1, wr ? "rand store" : "rand load");
        end
        idle(1'b1, "final idle");
        checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
